riscv_mul_arbiter: RTL and testbench



---
 rtl/riscv_mul_arbiter_pkg.sv | 39 +++
 rtl/riscv_mul_arbiter_if.sv | 42 ++++
 rtl/riscv_rr_arb2.sv | 12 +
 rtl/riscv_mul_arbiter.sv | 114 +++++++++++
 tb/tb_riscv_mul_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mul_arbiter_pkg.sv
// riscv_mul_arbiter_pkg: shared M-extension encodings, funct codes and instruction builder
// Contents:
//   MUL_FUNCT_*            request op codes (0=MUL,1=MULH,2=MULHSU,3=MULHU)
//   INST_MUL*/INST_*_MASK  instruction match/mask pairs for the multiply ops
//   MUL_RS1_IDX/RS2_IDX    fixed rs1/rs2 register indices written into the instruction
//   mul_fix_rd()           rd=0 is replaced by 1 so the multiplier always writes back
//   mul_inst()             full instruction word for a funct/rd pair
package riscv_mul_arbiter_pkg;

    localparam logic [1:0] MUL_FUNCT_MUL    = 2'd0;
    localparam logic [1:0] MUL_FUNCT_MULH   = 2'd1;
    localparam logic [1:0] MUL_FUNCT_MULHSU = 2'd2;
    localparam logic [1:0] MUL_FUNCT_MULHU  = 2'd3;

    localparam logic [31:0] INST_MUL         = 32'h02000033;
    localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
    localparam logic [31:0] INST_MULH        = 32'h02001033;
    localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
    localparam logic [31:0] INST_MULHSU      = 32'h02002033;
    localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_MULHU       = 32'h02003033;
    localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

    localparam logic [4:0] MUL_RS1_IDX = 5'd2;
    localparam logic [4:0] MUL_RS2_IDX = 5'd3;

    function automatic logic [4:0] mul_fix_rd(input logic [4:0] rd);
        return rd == 5'd0 ? 5'd1 : rd;
    endfunction

    function automatic logic [31:0] mul_inst(input logic [1:0] funct, input logic [4:0] rd);
        logic [31:0] base;
        base = funct == MUL_FUNCT_MULH   ? INST_MULH   :
               funct == MUL_FUNCT_MULHSU ? INST_MULHSU :
               funct == MUL_FUNCT_MULHU  ? INST_MULHU  : INST_MUL;
        return base | {7'b0, MUL_RS2_IDX, MUL_RS1_IDX, 3'b0, rd, 7'b0};
    endfunction

endpackage

// File: rtl/riscv_mul_arbiter_if.sv
// riscv_mul_arbiter_if: request, response and multiplier-side signals of the multiply arbiter
// Groups:
//   req_*        two valid/ready request channels (index = port id)
//   resp_*       single tagged response channel
//   mul_*        opcode interface towards riscv_multiplier, writeback_value_i back from it
//   busy_o       arbiter not idle
// Modports: slave = arbiter side, master = requester/multiplier side.
interface riscv_mul_arbiter_if;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][1:0]  req_funct_i;
    logic [1:0][31:0] req_a_i;
    logic [1:0][31:0] req_b_i;
    logic [1:0][4:0]  req_rd_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic             resp_id_o;
    logic [4:0]       resp_rd_o;
    logic [31:0]      resp_data_o;
    logic             mul_opcode_valid_o;
    logic [31:0]      mul_opcode_o;
    logic [31:0]      mul_ra_operand_o;
    logic [31:0]      mul_rb_operand_o;
    logic [4:0]       mul_rd_idx_o;
    logic             mul_hold_o;
    logic [31:0]      writeback_value_i;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_funct_i, req_a_i, req_b_i, req_rd_i, resp_ready_i, writeback_value_i,
        output req_ready_o, resp_valid_o, resp_id_o, resp_rd_o, resp_data_o,
               mul_opcode_valid_o, mul_opcode_o, mul_ra_operand_o, mul_rb_operand_o,
               mul_rd_idx_o, mul_hold_o, busy_o
    );

    modport master (
        output req_valid_i, req_funct_i, req_a_i, req_b_i, req_rd_i, resp_ready_i, writeback_value_i,
        input  req_ready_o, resp_valid_o, resp_id_o, resp_rd_o, resp_data_o,
               mul_opcode_valid_o, mul_opcode_o, mul_ra_operand_o, mul_rb_operand_o,
               mul_rd_idx_o, mul_hold_o, busy_o
    );
endinterface

// File: rtl/riscv_rr_arb2.sv
// riscv_rr_arb2: combinational two-requester round-robin picker
// Ports:
//   i_req   request vector
//   i_last  port granted last time; the other port wins a tie
//   o_gnt   one-hot grant (zero when nothing requests)
module riscv_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    always_comb o_gnt = (&i_req) ? (i_last ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/riscv_mul_arbiter.sv
// riscv_mul_arbiter: two-port round-robin sequencer for the shared riscv_multiplier
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-low reset
//   bus     riscv_mul_arbiter_if.slave: request channels, tagged response, multiplier opcode side
// One operation is in flight at a time: IDLE accepts, ISSUE pulses opcode valid,
// WAIT counts down the multiplier latency, RESP holds the result until accepted.
module riscv_mul_arbiter
    import riscv_mul_arbiter_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    riscv_mul_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [3:0]  r_cnt;
    logic        r_id;
    logic [4:0]  r_rd;
    logic [4:0]  r_rd_idx;
    logic [31:0] r_opcode;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_data;
    logic [1:0]  w_gnt;
    logic        w_sel;
    logic        w_accept;
    logic [1:0]  w_ready;
    logic        w_opv;
    logic        w_respv;

    riscv_rr_arb2 u_arb (
        .i_req  (bus.req_valid_i),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    assign w_sel = w_gnt[1];

    always_comb begin
        w_next   = r_state;
        w_ready  = 2'b00;
        w_opv    = 1'b0;
        w_respv  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready  = w_gnt;
                w_accept = |w_gnt;
                w_next   = w_accept ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                w_opv  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT:  w_next = r_cnt == 4'd1 ? S_RESP : S_WAIT;
            default: begin
                w_respv = 1'b1;
                w_next  = bus.resp_ready_i ? S_IDLE : S_RESP;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_cnt    <= 4'd0;
            r_id     <= 1'b0;
            r_rd     <= 5'd0;
            r_rd_idx <= 5'd0;
            r_opcode <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_data   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last   <= w_sel;
                r_id     <= w_sel;
                r_rd     <= bus.req_rd_i[w_sel];
                r_rd_idx <= mul_fix_rd(bus.req_rd_i[w_sel]);
                r_opcode <= mul_inst(bus.req_funct_i[w_sel], mul_fix_rd(bus.req_rd_i[w_sel]));
                r_a      <= bus.req_a_i[w_sel];
                r_b      <= bus.req_b_i[w_sel];
            end
            if (r_state == S_ISSUE)
                r_cnt <= 4'(MUL_LATENCY);
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 4'd1;
            // counter==1 marks the cycle in which the multiplier presents the result
            if (r_state == S_WAIT && r_cnt == 4'd1)
                r_data <= bus.writeback_value_i;
        end
    end

    assign bus.req_ready_o        = w_ready;
    assign bus.mul_opcode_valid_o = w_opv;
    assign bus.resp_valid_o       = w_respv;
    assign bus.resp_id_o          = r_id;
    assign bus.resp_rd_o          = r_rd;
    assign bus.resp_data_o        = r_data;
    assign bus.mul_opcode_o       = r_opcode;
    assign bus.mul_ra_operand_o   = r_a;
    assign bus.mul_rb_operand_o   = r_b;
    assign bus.mul_rd_idx_o       = r_rd_idx;
    assign bus.mul_hold_o         = 1'b0;
    assign bus.busy_o             = r_state != S_IDLE;
endmodule

// File: tb/tb_riscv_mul_arbiter.sv
// tb_riscv_mul_arbiter: scoreboard bench for riscv_mul_arbiter with a behavioural multiplier
module tb_riscv_mul_arbiter;
    localparam int LAT = 2;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic        id;
        logic [4:0]  rd;
        logic [31:0] d;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rr = 1'b1;
    logic [1:0] rv = 2'b00;
    op_t pl [2];
    logic [31:0] pipe [LAT];

    exp_t sb[$];
    int gnt_q[$];
    logic [31:0] rlog_d[$];
    logic rlog_id[$];
    op_t ops0[$];
    op_t ops1[$];
    op_t cur;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int opv_n = 0;
    logic prev_rv = 1'b0;

    always #5 clk = ~clk;

    riscv_mul_arbiter_if bus ();

    riscv_mul_arbiter #(.MUL_LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    assign bus.req_valid_i       = rv;
    assign bus.req_funct_i       = {pl[1].f, pl[0].f};
    assign bus.req_a_i           = {pl[1].a, pl[0].a};
    assign bus.req_b_i           = {pl[1].b, pl[0].b};
    assign bus.req_rd_i          = {pl[1].rd, pl[0].rd};
    assign bus.resp_ready_i      = rr;
    assign bus.writeback_value_i = pipe[LAT-1];

    function automatic logic [31:0] mulref(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [64:0] x, y, p;
        x = (f == 2'd1 || f == 2'd2) ? {{33{a[31]}}, a} : {33'b0, a};
        y = (f == 2'd1) ? {{33{b[31]}}, b} : {33'b0, b};
        p = x * y;
        return f == 2'd0 ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] inst_tab(input logic [1:0] f);
        case (f)
            2'd0:    return 32'h02000033;
            2'd1:    return 32'h02001033;
            2'd2:    return 32'h02002033;
            default: return 32'h02003033;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // behavioural multiplier: result appears LAT cycles after the opcode-valid cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 32'd0;
        end else begin
            pipe[0] <= bus.mul_opcode_valid_o ?
                       mulref(bus.mul_opcode_o[13:12], bus.mul_ra_operand_o, bus.mul_rb_operand_o) : 32'hdeadbeef;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            opv_n = 0;
        end
        chk("rdy_onehot", 32'($countones(bus.req_ready_o) <= 1), 1);
        chk("rdy_busy", 32'((|bus.req_ready_o) & bus.busy_o), 0);
        for (int p = 0; p < 2; p++) begin
            if (rv[p] && bus.req_ready_o[p]) begin
                sb.push_back(exp_t'{p[0], pl[p].rd, mulref(pl[p].f, pl[p].a, pl[p].b), cyc});
                gnt_q.push_back(p);
                cur = pl[p];
            end
        end
        if (bus.mul_opcode_valid_o) begin
            opv_n++;
            chk("opc_masked", bus.mul_opcode_o & 32'hfe00707f, inst_tab(cur.f));
            chk("opc_rs1", 32'(bus.mul_opcode_o[19:15]), 2);
            chk("opc_rs2", 32'(bus.mul_opcode_o[24:20]), 3);
            chk("opc_rd", 32'(bus.mul_opcode_o[11:7]), cur.rd == 5'd0 ? 32'd1 : 32'(cur.rd));
            chk("rd_idx", 32'(bus.mul_rd_idx_o), cur.rd == 5'd0 ? 32'd1 : 32'(cur.rd));
            chk("ra", bus.mul_ra_operand_o, cur.a);
            chk("rb", bus.mul_rb_operand_o, cur.b);
        end
        if (bus.resp_valid_o && !prev_rv && sb.size() > 0)
            chk("latency", 32'(cyc - sb[0].acc), LAT + 2);
        if (bus.resp_valid_o && rr) begin
            if (sb.size() == 0) begin
                chk("resp_extra", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 32'(bus.resp_id_o), 32'(e.id));
                chk("resp_rd", 32'(bus.resp_rd_o), 32'(e.rd));
                chk("resp_data", bus.resp_data_o, e.d);
                chk("issue_once", 32'(opv_n), 1);
                opv_n = 0;
                rlog_d.push_back(bus.resp_data_o);
                rlog_id.push_back(bus.resp_id_o);
            end
        end
        prev_rv = bus.resp_valid_o;
    end

    task automatic zero_outs(input string tag);
        chk({tag, "_ctl"}, 32'({bus.busy_o, bus.resp_valid_o, bus.resp_id_o, bus.mul_opcode_valid_o,
                                bus.mul_hold_o, bus.req_ready_o}), 0);
        chk({tag, "_opc"}, bus.mul_opcode_o, 0);
        chk({tag, "_ops"}, bus.mul_ra_operand_o | bus.mul_rb_operand_o, 0);
        chk({tag, "_rd"}, 32'({bus.mul_rd_idx_o, bus.resp_rd_o}), 0);
        chk({tag, "_data"}, bus.resp_data_o, 0);
    endtask

    // presents queued ops on both ports, holding valid until each handshake
    task automatic drive();
        int budget;
        logic a0, a1;
        budget = 0;
        while ((ops0.size() > 0 || ops1.size() > 0) && budget < 400) begin
            rv[0] = ops0.size() > 0;
            rv[1] = ops1.size() > 0;
            if (rv[0]) pl[0] = ops0[0];
            if (rv[1]) pl[1] = ops1[0];
            @(negedge clk);
            a0 = rv[0] & bus.req_ready_o[0];
            a1 = rv[1] & bus.req_ready_o[1];
            @(posedge clk);
            #1;
            if (a0) void'(ops0.pop_front());
            if (a1) void'(ops1.pop_front());
            budget++;
        end
        rv = 2'b00;
        if (budget >= 400) chk("drive_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy_o || sb.size() != 0) && n < 200);
        if (n >= 200) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold_d;
        logic hold_id;
        int n;
        pl[0] = op_t'{2'd0, 32'd0, 32'd0, 5'd0};
        pl[1] = op_t'{2'd0, 32'd0, 32'd0, 5'd0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_outs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rlog_d.delete(); rlog_id.delete();
        ops0.push_back(op_t'{2'd0, 32'd3, 32'd7, 5'd10});
        drive();
        wait_idle();
        chk("mul_data", rlog_d[0], 32'h00000015);
        chk("mul_id", 32'(rlog_id[0]), 0);

        rlog_d.delete(); rlog_id.delete();
        ops0.push_back(op_t'{2'd3, 32'hffff0000, 32'h0000ffff, 5'd0});
        drive();
        wait_idle();
        chk("mulhu_data", rlog_d[0], 32'h0000fffe);

        rlog_d.delete(); rlog_id.delete();
        ops1.push_back(op_t'{2'd1, 32'hfffffffe, 32'd7, 5'd31});
        drive();
        wait_idle();
        chk("mulh_data", rlog_d[0], 32'hffffffff);
        chk("mulh_id", 32'(rlog_id[0]), 1);

        gnt_q.delete();
        ops0.push_back(op_t'{2'd0, 32'h12345678, 32'd9, 5'd1});
        ops0.push_back(op_t'{2'd2, 32'hfffffffb, 32'd3, 5'd2});
        ops0.push_back(op_t'{2'd3, 32'hffffffff, 32'hffffffff, 5'd3});
        ops1.push_back(op_t'{2'd1, 32'h80000000, 32'h80000000, 5'd4});
        ops1.push_back(op_t'{2'd0, 32'hffffffff, 32'hffffffff, 5'd5});
        ops1.push_back(op_t'{2'd2, 32'hffffffff, 32'hffffffff, 5'd6});
        drive();
        wait_idle();
        chk("alt_count", 32'(gnt_q.size()), 6);
        for (int i = 0; i < gnt_q.size(); i++) chk("alt_grant", 32'(gnt_q[i]), 32'(i % 2));

        rr = 1'b0;
        ops0.push_back(op_t'{2'd0, 32'd100, 32'd200, 5'd4});
        drive();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.resp_valid_o && n < 20);
        chk("stall_seen", 32'(bus.resp_valid_o), 1);
        hold_d = bus.resp_data_o;
        hold_id = bus.resp_id_o;
        chk("stall_val", hold_d, 32'd20000);
        rv = 2'b11;
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.resp_valid_o), 1);
            chk("stall_data", bus.resp_data_o, hold_d);
            chk("stall_id", 32'(bus.resp_id_o), 32'(hold_id));
            chk("stall_rdy", 32'(bus.req_ready_o), 0);
        end
        @(posedge clk);
        #1;
        rv = 2'b00;
        rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_stall_valid", 32'(bus.resp_valid_o), 0);
        chk("post_stall_busy", 32'(bus.busy_o), 0);
        chk("post_stall_sb", 32'(sb.size()), 0);
        @(posedge clk);
        #1;

        ops0.push_back(op_t'{2'd0, 32'd9, 32'd9, 5'd7});
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        zero_outs("rst_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_resp", 32'(bus.resp_valid_o), 0);
        end
        @(posedge clk);
        #1;

        gnt_q.delete(); rlog_d.delete(); rlog_id.delete();
        ops0.push_back(op_t'{2'd0, 32'd5, 32'd5, 5'd0});
        ops1.push_back(op_t'{2'd0, 32'd2, 32'd2, 5'd6});
        drive();
        wait_idle();
        chk("tie_first", 32'(gnt_q[0]), 0);
        chk("tie_data", rlog_d[0], 32'h00000019);
        chk("tie_id", 32'(rlog_id[0]), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
